vend_input_conditioner: RTL and testbench
=========================================

Name: vend_input_conditioner

Overview:
Upstream front-end for the vending FSM. Synchronises and debounces the raw coin switches and product-select buttons. Emits a single-cycle one-hot coin pulse on i[2:0], which the vending FSM samples in its idle state. Holds a clean one-hot product selection on sel[3:0] for the whole vend, and locks out further coins until the downstream FSM is back in idle.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples that must differ from the debounced value before that value flips; legal range 2..255.
LOCK_CYCLES, 3, cycles after a coin pulse during which new coins are rejected; this matches the downstream idle->coin state->DISPENSE->idle path.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
coin_raw  in  3  raw coin switches: bit0 small, bit1 medium, bit2 large; asynchronous and bouncy
sel_raw  in  4  raw product buttons, one per product; asynchronous and bouncy
i  out  3  one-hot coin pulse to the vending FSM, high for exactly one cycle
sel  out  4  latched one-hot product selection to the vending FSM, 0 = none
coin_err  out  1  one-cycle pulse when a coin event is rejected
busy  out  1  high in the PULSE and LOCK states

Behaviour:
- Reset (asynchronous, active-high): i=0, sel=0, coin_err=0, busy=0. Clears all synchronisers, debounced values and counters. FSM goes to IDLE. Applies mid-operation too; a pulse in flight is killed.
- Synchronisation: each of the 7 raw bits passes through a 2-flop synchroniser.
- Debounce, per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while the synchronised sample != the debounced value, and resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced value.
- Edge detect: a rise is debounced 0->1, one cycle wide.
- Coin latency: for a clean raw rise, i is asserted in the cycle after edge 2+DEBOUNCE_CYCLES+1, counted from the first clock edge at which the raw level is high. Falls are ignored.
- FSM (2-bit encoding, states in package):
  - IDLE: exactly one coin rise in a cycle -> i = that one-hot value on the next edge, go to PULSE. More than one coin rise in the same cycle -> coin_err pulse, no i pulse, stay in IDLE.
  - PULSE: i held for this single cycle. Load the lock counter with LOCK_CYCLES-1, go to LOCK. i returns to 0 on the next edge.
  - LOCK: decrement the lock counter; on 0, go to IDLE. Any coin rise in PULSE or LOCK -> coin_err pulse and the coin is discarded, never queued.
- Selection latch:
  - A single select rise in any state other than PULSE/LOCK loads sel with that one-hot value.
  - Multiple select rises in the same cycle are ignored; sel is kept.
  - sel is frozen during PULSE and LOCK, so the downstream FSM sees a stable value in its coin state.
  - sel clears to 0 on the edge where LOCK exits to IDLE.
- Simultaneous events:
  - A coin rise and a select rise in the same IDLE cycle are both accepted. sel updates on the same edge that i asserts.
  - A coin rise in the LOCK exit cycle is rejected, not accepted.
- Outputs are registered; nothing is combinational from input to output.

Decomposition:
- Package vend_pkg holds:
  - FSM state typedef: IDLE, PULSE, LOCK.
  - Coin one-hot constants: COIN_S=3'b001, COIN_M=3'b010, COIN_L=3'b100.
  - Product count constant: 4.
- One sub-module, vend_debounce: a single bit with its 2-flop synchroniser, DEBOUNCE_CYCLES counter, debounced level and rise pulse. Instantiated 7 times via generate.
- Onehot/multi-hot detection and the FSM stay in the top module.

Test Plan:
- Reset mid-pulse: assert rst while i=001 -> i, sel, busy, coin_err all 0 immediately (asynchronous); FSM in IDLE; no pulse after release.
- Clean small coin, DEBOUNCE_CYCLES=4: coin_raw=001 held 20 cycles -> i=001 for exactly 1 cycle, 7 edges after the first sampled high edge; busy high for 1+3 cycles.
- Bounce: coin_raw toggles 001/000 every 2 cycles for 12 cycles, then stays 000 -> i stays 000 and coin_err stays 0 throughout.
- Select then coin: sel_raw=0100 stable, then coin_raw=010 -> sel=0100 before i=010; sel stable through LOCK; sel=0000 after the LOCK exit edge.
- Double coin: coin_raw 000->101 in one cycle -> one coin_err pulse; i stays 000; FSM stays IDLE.
- Coin in lockout: large coin accepted, second coin rise lands 1 cycle into LOCK -> coin_err pulse, no second i pulse; a third coin after IDLE is accepted normally.

Source files
------------

// File: rtl/vend_input_conditioner_pkg.sv
// vend_pkg: shared FSM state type and coin/product constants for the vending input front-end
package vend_pkg;
   typedef enum logic [1:0] {IDLE, PULSE, LOCK} state_t;
   localparam logic [2:0] COIN_S = 3'b001;
   localparam logic [2:0] COIN_M = 3'b010;
   localparam logic [2:0] COIN_L = 3'b100;
   localparam int NUM_PROD = 4;
endpackage

// File: rtl/vend_input_conditioner_if.sv
// vend_input_conditioner_if: raw switch inputs and conditioned outputs of the vending front-end
interface vend_input_conditioner_if;
   import vend_pkg::*;
   logic [2:0]          coin_raw;
   logic [NUM_PROD-1:0] sel_raw;
   logic [2:0]          i;
   logic [NUM_PROD-1:0] sel;
   logic                coin_err;
   logic                busy;
   modport slave (input coin_raw, sel_raw, output i, sel, coin_err, busy);
   modport master (output coin_raw, sel_raw, input i, sel, coin_err, busy);
endinterface

// File: rtl/vend_debounce.sv
// vend_debounce: 2-flop synchroniser plus counter debounce for one raw bit, with a one-cycle rise pulse
module vend_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level;
   // the flip happens on the edge the counter would reach DEBOUNCE_CYCLES
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync[1];
            rise  <= sync[1];
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/vend_input_conditioner.sv
// vend_input_conditioner: debounces coins and selects, emits one-hot coin pulses and
// holds the product selection while locking out coins until the vend completes
module vend_input_conditioner
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCK_CYCLES     = 3
) (
   input  logic clk,
   input  logic rst,
   vend_input_conditioner_if.slave bus
);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   logic [NUM_PROD+2:0] raw, rise;
   logic [2:0]          coin_rise;
   logic [NUM_PROD-1:0] sel_rise;
   logic [LW-1:0]       lock_cnt;
   state_t              state;
   assign raw       = {bus.sel_raw, bus.coin_raw};
   assign coin_rise = rise[2:0];
   assign sel_rise  = rise[NUM_PROD+2:3];
   for (genvar b = 0; b < NUM_PROD + 3; b++) begin : g_db
      vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw[b]),
         .rise (rise[b])
      );
   end
   // coins arriving outside IDLE are rejected outright, never queued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         lock_cnt     <= '0;
         bus.i        <= '0;
         bus.sel      <= '0;
         bus.coin_err <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         bus.i        <= '0;
         bus.coin_err <= |coin_rise;
         if (state == IDLE && $onehot(sel_rise)) bus.sel <= sel_rise;
         case (state)
            IDLE: if ($onehot(coin_rise)) begin
               bus.i        <= coin_rise;
               bus.coin_err <= 1'b0;
               bus.busy     <= 1'b1;
               state        <= PULSE;
            end
            PULSE: begin
               lock_cnt <= LW'(LOCK_CYCLES - 1);
               state    <= LOCK;
            end
            LOCK: if (lock_cnt == '0) begin
               bus.sel  <= '0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end else lock_cnt <= lock_cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vend_input_conditioner.sv
// tb_vend_input_conditioner: directed checks of debounce latency, lockout, selection latch and reset
module tb_vend_input_conditioner;
   import vend_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0, n_err = 0;
   int first_i, n_i, last_i, n_busy, n_cerr, first_cerr;
   vend_input_conditioner_if vif();
   vend_input_conditioner #(.DEBOUNCE_CYCLES(4), .LOCK_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif.slave)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // cycle k is sampled 1 time unit after the k-th edge following the stimulus change
   task automatic run(input int n);
      first_i = 0; n_i = 0; last_i = 0; n_busy = 0; n_cerr = 0; first_cerr = 0;
      for (int k = 1; k <= n; k++) begin
         step();
         if (vif.i != 0) begin
            n_i++;
            last_i = int'(vif.i);
            if (first_i == 0) first_i = k;
         end
         if (vif.busy) n_busy++;
         if (vif.coin_err) begin
            n_cerr++;
            if (first_cerr == 0) first_cerr = k;
         end
      end
   endtask

   initial begin
      vif.coin_raw = '0;
      vif.sel_raw  = '0;
      idle(3);
      chk("rst_i", int'(vif.i), 0);
      chk("rst_sel", int'(vif.sel), 0);
      chk("rst_err", int'(vif.coin_err), 0);
      chk("rst_busy", int'(vif.busy), 0);
      rst = 1'b0;
      idle(3);

      vif.coin_raw = COIN_S;
      run(20);
      chk("clean_lat", first_i, 7);
      chk("clean_pulses", n_i, 1);
      chk("clean_val", last_i, 1);
      chk("clean_busy", n_busy, 4);
      chk("clean_err", n_cerr, 0);
      vif.coin_raw = '0;
      idle(10);

      for (int k = 0; k < 12; k++) begin
         vif.coin_raw = (k % 4 < 2) ? COIN_S : 3'b000;
         run(1);
         chk("bounce_i", n_i, 0);
         chk("bounce_err", n_cerr, 0);
      end
      vif.coin_raw = '0;
      run(10);
      chk("bounce_tail_i", n_i, 0);

      vif.sel_raw = 4'b0100;
      run(10);
      chk("sel_latched", int'(vif.sel), 4);
      chk("sel_no_i", n_i, 0);
      vif.coin_raw = COIN_M;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 6) chk("sel_pre_i", int'(vif.i), 0);
         if (k == 7) chk("sel_coin_i", int'(vif.i), 2);
         if (k >= 7 && k <= 10) chk("sel_frozen", int'(vif.sel), 4);
         if (k == 11) chk("sel_cleared", int'(vif.sel), 0);
         if (k == 11) chk("sel_busy_off", int'(vif.busy), 0);
      end
      vif.coin_raw = '0;
      vif.sel_raw  = '0;
      idle(10);

      vif.coin_raw = 3'b101;
      run(12);
      chk("dbl_err_cnt", n_cerr, 1);
      chk("dbl_err_at", first_cerr, 7);
      chk("dbl_i", n_i, 0);
      chk("dbl_busy", n_busy, 0);
      vif.coin_raw = '0;
      idle(10);

      vif.coin_raw = COIN_L;
      idle(3);
      vif.coin_raw = COIN_L | COIN_S;
      run(12);
      chk("lock_i_at", first_i, 4);
      chk("lock_i_cnt", n_i, 1);
      chk("lock_i_val", last_i, 4);
      chk("lock_err_cnt", n_cerr, 1);
      chk("lock_err_at", first_cerr, 7);
      vif.coin_raw = '0;
      idle(10);

      vif.coin_raw = COIN_L;
      idle(4);
      vif.coin_raw = COIN_L | COIN_M;
      run(12);
      chk("exit_i_cnt", n_i, 1);
      chk("exit_err_at", first_cerr, 7);
      chk("exit_err_cnt", n_cerr, 1);
      vif.coin_raw = '0;
      idle(10);

      vif.coin_raw = COIN_M;
      run(12);
      chk("third_lat", first_i, 7);
      chk("third_val", last_i, 2);
      chk("third_err", n_cerr, 0);
      vif.coin_raw = '0;
      idle(10);

      vif.coin_raw = COIN_S;
      vif.sel_raw  = 4'b0001;
      run(7);
      chk("rstmid_i_at", first_i, 7);
      chk("rstmid_i", int'(vif.i), 1);
      chk("rstmid_sel", int'(vif.sel), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_i_clr", int'(vif.i), 0);
      chk("rstmid_sel_clr", int'(vif.sel), 0);
      chk("rstmid_busy_clr", int'(vif.busy), 0);
      chk("rstmid_err_clr", int'(vif.coin_err), 0);
      vif.coin_raw = '0;
      vif.sel_raw  = '0;
      idle(2);
      rst = 1'b0;
      run(15);
      chk("post_rst_i", n_i, 0);
      chk("post_rst_busy", n_busy, 0);
      chk("post_rst_sel", int'(vif.sel), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
